// File: rtl/rom_download_sequencer.sv
// Cartridge ROM download sequencer: strips an optional copier header from the bridge word
// stream, issues acknowledged 16-bit SDRAM writes, then settles and latches the parsed ROM type.
module rom_download_sequencer #(
    parameter int ADDR_W        = 25,
    parameter int HDR_BYTES     = 512,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       rom_file_size,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       data,
    output logic              wr,
    input  logic              mem_ack,
    output logic              downloading,
    input  logic [2:0]        parsed_rom_type,
    output logic [2:0]        rom_type,
    output logic              done,
    output logic              error
);
    localparam int HDR_WORDS = HDR_BYTES / 2;
    localparam int HCNT_W    = $clog2(HDR_WORDS + 1);
    localparam int SCNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HDR_LAST    = HCNT_W'(HDR_WORDS - 1);
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE    = HCNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_ONE    = SCNT_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE     = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SKIP_HDR, S_WRITE, S_SETTLE, S_DONE
    } state_t;

    state_t              state_reg;
    logic [31:0]         size_reg;
    logic [ADDR_W-1:0]   words_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic                odd_reg;
    logic [HCNT_W-1:0]   hdr_cnt_reg;
    logic [SCNT_W-1:0]   settle_cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [15:0]         data_reg;
    logic                wr_reg;
    logic                downloading_reg;
    logic [2:0]          rom_type_reg;
    logic                done_reg;
    logic                error_reg;

    // Size decode, evaluated from the latched size while in CHECK; 33-bit so no size overflows.
    logic                hdr_c;
    logic [32:0]         payload_c;
    logic                too_big_c;
    logic [ADDR_W-1:0]   words_c;
    logic                last_word;

    assign hdr_c     = (size_reg[9:0] == 10'(HDR_BYTES));
    assign payload_c = {1'b0, size_reg} - (hdr_c ? 33'(HDR_BYTES) : 33'd0);
    assign too_big_c = payload_c > (33'd1 << ADDR_W);
    assign words_c   = payload_c[ADDR_W:1] + {{(ADDR_W-1){1'b0}}, payload_c[0]};
    assign last_word = (idx_reg + IDX_ONE == words_reg);

    assign in_ready    = (state_reg == S_SKIP_HDR) || (state_reg == S_WRITE && !wr_reg);
    assign addr        = addr_reg;
    assign data        = data_reg;
    assign wr          = wr_reg;
    assign downloading = downloading_reg;
    assign rom_type    = rom_type_reg;
    assign done        = done_reg;
    assign error       = error_reg;

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            size_reg        <= '0;
            words_reg       <= '0;
            idx_reg         <= '0;
            odd_reg         <= 1'b0;
            hdr_cnt_reg     <= '0;
            settle_cnt_reg  <= '0;
            addr_reg        <= '0;
            data_reg        <= '0;
            wr_reg          <= 1'b0;
            downloading_reg <= 1'b0;
            rom_type_reg    <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else if (abort) begin
            state_reg       <= S_IDLE;
            wr_reg          <= 1'b0;
            downloading_reg <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        size_reg  <= rom_file_size;
                        done_reg  <= 1'b0;
                        error_reg <= 1'b0;
                        state_reg <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    idx_reg        <= '0;
                    hdr_cnt_reg    <= '0;
                    settle_cnt_reg <= '0;
                    words_reg      <= words_c;
                    odd_reg        <= payload_c[0];
                    if (too_big_c) begin
                        error_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        downloading_reg <= 1'b1;
                        if (hdr_c)
                            state_reg <= S_SKIP_HDR;
                        else if (words_c == '0)
                            state_reg <= S_SETTLE;
                        else
                            state_reg <= S_WRITE;
                    end
                end
                S_SKIP_HDR: begin
                    if (in_valid) begin
                        hdr_cnt_reg <= hdr_cnt_reg + HCNT_ONE;
                        if (hdr_cnt_reg == HDR_LAST)
                            state_reg <= (words_reg == '0) ? S_SETTLE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_reg) begin
                        if (mem_ack) begin
                            wr_reg <= 1'b0;
                            if (idx_reg == words_reg)
                                state_reg <= S_SETTLE;
                        end
                    end else if (in_valid) begin
                        wr_reg   <= 1'b1;
                        addr_reg <= {idx_reg[ADDR_W-2:0], 1'b0};
                        // An odd payload leaves the upper byte of the final word past end of file.
                        data_reg <= (last_word && odd_reg) ? {8'h00, in_data[7:0]} : in_data;
                        idx_reg  <= idx_reg + IDX_ONE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        rom_type_reg    <= parsed_rom_type;
                        downloading_reg <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= S_DONE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + SCNT_ONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
